// File: rtl/decoder_scan_sequencer.sv
// Scans a binary select code through the code space, holding each address
// for DWELL cycles. Registered one-hot and valid. Optional macro: BIDIR_SCAN_EN.
module decoder_scan_sequencer #(
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [SEL_W-1:0]   start_addr,
   input  logic               cont,
   input  logic               hold,
   input  logic               stop,
`ifdef BIDIR_SCAN_EN
   input  logic               dir,
`endif
   output logic [SEL_W-1:0]   sel,
   output logic               sel_valid,
   output logic [2**SEL_W-1:0] onehot,
   output logic               busy,
   output logic               done
);

   localparam int OH_W = 2**SEL_W;
   localparam int CW   = (DWELL <= 1) ? 1 : $clog2(DWELL);
   localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DWELL,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  sel_d;
   logic              valid_q;
   logic [OH_W-1:0]   onehot_q;
   logic              busy_q;
   logic              done_q;
   logic [CW-1:0]     cnt_q;
   logic              down;
   logic              last;

   function automatic logic [OH_W-1:0] dec(input logic [SEL_W-1:0] a);
      logic [OH_W-1:0] r;
      r    = '0;
      r[a] = 1'b1;
      return r;
   endfunction

`ifdef BIDIR_SCAN_EN
   logic dir_q;

   // Scan direction is latched with start and held for the whole pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q <= 1'b0;
      end else if (state_q == S_IDLE && start) begin
         dir_q <= dir;
      end
   end

   assign down = dir_q;
`else
   assign down = 1'b0;
`endif

   // Next address and end-of-range detection for the current direction
   always_comb begin
      sel_d = sel_q;
      last  = 1'b0;
      if (down) begin
         sel_d = sel_q - SEL_W'(1);
         last  = (sel_q == '0);
      end else begin
         sel_d = sel_q + SEL_W'(1);
         last  = (sel_q == '1);
      end
   end

   // Scan FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         onehot_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  sel_q    <= start_addr;
                  onehot_q <= dec(start_addr);
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= S_DWELL;
               end
            end
            S_DWELL: begin
               if (stop) begin
                  valid_q  <= 1'b0;
                  onehot_q <= '0;
                  busy_q   <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= S_IDLE;
               end else if (hold) begin
                  cnt_q <= cnt_q;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + CW'(1);
               end else begin
                  cnt_q <= '0;
                  if (last && !cont) begin
                     valid_q  <= 1'b0;
                     onehot_q <= '0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     sel_q    <= sel_d;
                     onehot_q <= dec(sel_d);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign sel       = sel_q;
   assign sel_valid = valid_q;
   assign onehot    = onehot_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer: DWELL=4 and DWELL=1 instances.
// Bidirectional vectors run only when BIDIR_SCAN_EN is defined.
module tb_decoder_scan_sequencer;

   logic       clk;
   logic       rst_n;

   logic       start, cont, hold, stop;
   logic [2:0] start_addr;
   logic [2:0] sel;
   logic       sel_valid, busy, done;
   logic [7:0] onehot;

   logic       start2, cont2, hold2, stop2;
   logic [2:0] start_addr2;
   logic [2:0] sel2;
   logic       sel_valid2, busy2, done2;
   logic [7:0] onehot2;

`ifdef BIDIR_SCAN_EN
   logic       dir, dir2;
`endif

   int nchk;
   int nerr;

   decoder_scan_sequencer #(.SEL_W(3), .DWELL(4)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .cont       (cont),
      .hold       (hold),
      .stop       (stop),
`ifdef BIDIR_SCAN_EN
      .dir        (dir),
`endif
      .sel        (sel),
      .sel_valid  (sel_valid),
      .onehot     (onehot),
      .busy       (busy),
      .done       (done)
   );

   decoder_scan_sequencer #(.SEL_W(3), .DWELL(1)) u_d1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start2),
      .start_addr (start_addr2),
      .cont       (cont2),
      .hold       (hold2),
      .stop       (stop2),
`ifdef BIDIR_SCAN_EN
      .dir        (dir2),
`endif
      .sel        (sel2),
      .sel_valid  (sel_valid2),
      .onehot     (onehot2),
      .busy       (busy2),
      .done       (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fd;
      logic dseen;
      nchk = 0;
      nerr = 0;
      rst_n = 1'b0;
      start = 0; cont = 0; hold = 0; stop = 0; start_addr = '0;
      start2 = 0; cont2 = 0; hold2 = 0; stop2 = 0; start_addr2 = '0;
`ifdef BIDIR_SCAN_EN
      dir = 0; dir2 = 0;
`endif
      #23;
      chk("rst_sel", 32'(sel), 0);
      chk("rst_valid", 32'(sel_valid), 0);
      chk("rst_onehot", 32'(onehot), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      rst_n = 1'b1;
      step();

      // single pass from 0, DWELL=4
      start = 1; start_addr = 3'd0; cont = 0;
      fd = 0;
      for (int k = 1; k <= 34; k++) begin
         step();
         if (k == 1) start = 0;
         if (done && fd == 0) fd = k;
         if (k <= 32) begin
            chk("sp_sel", 32'(sel), 32'((k - 1) / 4));
            chk("sp_oh", 32'(onehot), 32'(1) << ((k - 1) / 4));
            chk("sp_valid", 32'(sel_valid), 1);
            chk("sp_busy", 32'(busy), 1);
            chk("sp_done", 32'(done), 0);
         end
         if (k == 33) begin
            chk("sp_end_valid", 32'(sel_valid), 0);
            chk("sp_end_oh", 32'(onehot), 0);
            chk("sp_end_busy", 32'(busy), 0);
         end
         if (k == 34) chk("sp_done_pulse", 32'(done), 0);
      end
      chk("sp_done_lat", 32'(fd), 33);

      // continuous scan from 6 wraps to 0
      start = 1; start_addr = 3'd6; cont = 1;
      step();
      start = 0;
      dseen = done;
      chk("ct_sel6", 32'(sel), 6);
      chk("ct_oh6", 32'(onehot), 32'h40);
      for (int k = 0; k < 4; k++) begin step(); dseen |= done; end
      chk("ct_sel7", 32'(sel), 7);
      chk("ct_oh7", 32'(onehot), 32'h80);
      for (int k = 0; k < 4; k++) begin step(); dseen |= done; end
      chk("ct_sel0", 32'(sel), 0);
      chk("ct_oh0", 32'(onehot), 32'h01);
      for (int k = 0; k < 4; k++) begin step(); dseen |= done; end
      chk("ct_sel1", 32'(sel), 1);
      chk("ct_valid", 32'(sel_valid), 1);
      chk("ct_no_done", 32'(dseen), 0);
      stop = 1;
      step();
      stop = 0; cont = 0;
      chk("ct_stop_valid", 32'(sel_valid), 0);
      chk("ct_stop_sel", 32'(sel), 1);
      step();

      // hold extends sel=2 by three cycles, then stop wins over hold
      start = 1; start_addr = 3'd0;
      step();
      start = 0;
      for (int k = 0; k < 8; k++) step();
      chk("hd_sel2", 32'(sel), 2);
      hold = 1;
      for (int k = 0; k < 3; k++) step();
      hold = 0;
      chk("hd_held", 32'(sel), 2);
      for (int k = 0; k < 3; k++) step();
      chk("hd_ext", 32'(sel), 2);
      step();
      chk("hd_sel3", 32'(sel), 3);
      chk("hd_oh3", 32'(onehot), 32'h08);
      stop = 1; hold = 1;
      step();
      stop = 0; hold = 0;
      chk("sh_valid", 32'(sel_valid), 0);
      chk("sh_oh", 32'(onehot), 0);
      chk("sh_busy", 32'(busy), 0);
      chk("sh_done", 32'(done), 0);
      chk("sh_sel", 32'(sel), 3);
      step();
      chk("sh_idle", 32'(busy), 0);

      // DWELL=1: advance every cycle, start while busy ignored
      start2 = 1; start_addr2 = 3'd5; cont2 = 0;
      step();
      start_addr2 = 3'd1;
      chk("d1_sel5", 32'(sel2), 5);
      chk("d1_oh5", 32'(onehot2), 32'h20);
      step();
      chk("d1_sel6", 32'(sel2), 6);
      step();
      chk("d1_sel7", 32'(sel2), 7);
      chk("d1_oh7", 32'(onehot2), 32'h80);
      chk("d1_nodone", 32'(done2), 0);
      step();
      chk("d1_done", 32'(done2), 1);
      chk("d1_valid0", 32'(sel_valid2), 0);
      step();
      chk("d1_done_off", 32'(done2), 0);
      chk("d1_start_in_done", 32'(sel_valid2), 0);
      start2 = 0;
      step();

`ifdef BIDIR_SCAN_EN
      // downward continuous scan from 2 wraps to 7
      start = 1; start_addr = 3'd2; cont = 1; dir = 1;
      step();
      start = 0; dir = 0;
      chk("bd_sel2", 32'(sel), 2);
      chk("bd_oh2", 32'(onehot), 32'h04);
      for (int k = 0; k < 4; k++) step();
      chk("bd_sel1", 32'(sel), 1);
      chk("bd_oh1", 32'(onehot), 32'h02);
      for (int k = 0; k < 4; k++) step();
      chk("bd_sel0", 32'(sel), 0);
      chk("bd_oh0", 32'(onehot), 32'h01);
      for (int k = 0; k < 4; k++) step();
      chk("bd_sel7", 32'(sel), 7);
      chk("bd_oh7", 32'(onehot), 32'h80);
      for (int k = 0; k < 4; k++) step();
      chk("bd_sel6", 32'(sel), 6);
      chk("bd_oh6", 32'(onehot), 32'h40);
      stop = 1;
      step();
      stop = 0; cont = 0;
`endif

      // asynchronous reset mid-scan at sel=5
      start = 1; start_addr = 3'd4; cont = 1;
      step();
      start = 0;
      for (int k = 0; k < 5; k++) step();
      chk("ar_pre_sel", 32'(sel), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_sel", 32'(sel), 0);
      chk("ar_oh", 32'(onehot), 0);
      chk("ar_valid", 32'(sel_valid), 0);
      chk("ar_busy", 32'(busy), 0);
      #10;
      rst_n = 1'b1;
      cont = 0;
      step();
      chk("ar_idle", 32'(sel_valid), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
